// File: rtl/req_ack_responder.sv
// req_ack_responder
//
// Answers each rising edge of req with one single-cycle ack after a
// programmable delay. One single-cycle done follows 1 or 2 cycles after
// that ack. Rising edges that arrive while a transaction is running are
// counted and served in arrival order. If the count is already full, the
// edge is dropped and overflow pulses for one cycle.
//
// Parameters:
//   DLY_W    - width of cfg_ack_dly (ack delay 0..2^DLY_W-1 cycles)
//   MAX_PEND - maximum number of queued request edges
// Ports:
//   clk          - clock, all logic on posedge
//   rst          - asynchronous active-high reset
//   req          - request level; only rising edges matter
//   cfg_ack_dly  - ack delay D, latched when a transaction starts
//   cfg_done_dly - 0: done 1 cycle after ack, 1: done 2 cycles after ack
//   ack          - single-cycle acknowledge pulse
//   done         - single-cycle completion pulse
//   busy         - a transaction is in flight
//   pend_cnt     - queued requests that have not started yet
//   overflow     - single-cycle pulse when a request edge was dropped
module req_ack_responder #(
  parameter  int DLY_W    = 3,
  parameter  int MAX_PEND = 3,
  localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DLY_W-1:0]  cfg_ack_dly,
  input  logic              cfg_done_dly,
  output logic              ack,
  output logic              done,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, DLY, ACK, GAP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [DLY_W-1:0]   cnt_reg, cnt_next;
  logic               dd_reg, dd_next;
  logic [PEND_W-1:0]  pend_reg, pend_next;
  logic               ovf_reg, ovf_next;
  logic               req_q;
  logic               rose;
  logic               start;

  // req_q resets to 0, so a req already high at reset release is a rise.
  assign rose = req & ~req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dd_reg    <= 1'b0;
      pend_reg  <= '0;
      ovf_reg   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dd_reg    <= dd_next;
      pend_reg  <= pend_next;
      ovf_reg   <= ovf_next;
      req_q     <= req;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dd_next    = dd_reg;
    pend_next  = pend_reg;
    ovf_next   = 1'b0;
    start      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rose) start = 1'b1;
      end
      DLY: begin
        if (cnt_reg == '0) state_next = ACK;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ACK: begin
        state_next = dd_reg ? GAP : DONE;
      end
      GAP: begin
        state_next = DONE;
      end
      DONE: begin
        // A queued request is served before a simultaneous new edge. The new
        // edge takes the freed slot, so the count stays the same. That also
        // holds when the queue is full, so no edge is dropped here.
        if (pend_reg != '0) begin
          start = 1'b1;
          if (!rose) pend_next = pend_reg - 1'b1;
        end else if (rose) begin
          start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Edges seen mid-transaction are queued, or dropped when the queue is full.
    if (rose && (state_reg == DLY || state_reg == ACK || state_reg == GAP)) begin
      if (pend_reg == PEND_W'(MAX_PEND)) ovf_next  = 1'b1;
      else                               pend_next = pend_reg + 1'b1;
    end

    // Config is captured only here, so later changes to it cannot disturb
    // the transaction that is already running.
    if (start) begin
      state_next = DLY;
      cnt_next   = cfg_ack_dly;
      dd_next    = cfg_done_dly;
    end
  end

  assign ack      = (state_reg == ACK);
  assign done     = (state_reg == DONE);
  assign busy     = (state_reg != IDLE);
  assign pend_cnt = pend_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_req_ack_responder.sv
module tb_req_ack_responder;

  localparam int MAX_PEND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] cfg_ack_dly;
  logic       cfg_done_dly;
  logic       ack, done, busy, overflow;
  logic [1:0] pend_cnt;

  req_ack_responder #(.DLY_W(3), .MAX_PEND(MAX_PEND)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .cfg_ack_dly  (cfg_ack_dly),
    .cfg_done_dly (cfg_done_dly),
    .ack          (ack),
    .done         (done),
    .busy         (busy),
    .pend_cnt     (pend_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: timestamps of the running transaction plus a pending count.
  int e = 0;              // index of the upcoming posedge
  bit m_active = 1'b0;
  int m_start, m_ack_t, m_done_t;
  int m_pend = 0;
  bit m_ovf = 1'b0;
  bit m_req_prev = 1'b0;

  // Pulses seen on the DUT outputs, used by the directed scenarios.
  int obs_ack, obs_done, obs_ovf, obs_maxpend;
  int last_ack_e, last_done_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, e, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_pend     = 0;
    m_ovf      = 1'b0;
    m_req_prev = 1'b0;
  endtask

  task automatic start_txn(input int d, input int ddv);
    m_active = 1'b1;
    m_start  = e;
    m_ack_t  = e + 2 + d;
    m_done_t = e + 3 + d + ddv;
  endtask

  task automatic clear_obs();
    obs_ack = 0; obs_done = 0; obs_ovf = 0; obs_maxpend = 0;
  endtask

  // Called at a negedge: check outputs for edge e, drive inputs for it, advance model.
  task automatic step(input logic r, input logic [2:0] d, input logic ddv);
    bit rose;
    check_eq("ack",      32'(ack),      32'(m_active && e == m_ack_t));
    check_eq("done",     32'(done),     32'(m_active && e == m_done_t));
    check_eq("busy",     32'(busy),     32'(m_active && e > m_start && e <= m_done_t));
    check_eq("pend_cnt", 32'(pend_cnt), 32'(m_pend));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (ack === 1'b1) begin obs_ack++; last_ack_e = e; end
    if (done === 1'b1) begin
      obs_done++; last_done_e = e;
      $display("txn: ack at edge %0d, done at edge %0d", last_ack_e, e);
    end
    if (overflow === 1'b1) obs_ovf++;
    if (int'(pend_cnt) > obs_maxpend) obs_maxpend = int'(pend_cnt);

    req          = r;
    cfg_ack_dly  = d;
    cfg_done_dly = ddv;
    rose         = r && !m_req_prev;
    m_req_prev   = r;

    if (m_active && e == m_done_t) begin
      m_ovf = 1'b0;
      if (m_pend > 0) begin
        if (!rose) m_pend--;
        start_txn(int'(d), int'(ddv));
      end else if (rose) begin
        start_txn(int'(d), int'(ddv));
      end else begin
        m_active = 1'b0;
      end
    end else if (m_active) begin
      m_ovf = 1'b0;
      if (rose) begin
        if (m_pend == MAX_PEND) m_ovf = 1'b1;
        else                    m_pend++;
      end
    end else begin
      m_ovf = 1'b0;
      if (rose) start_txn(int'(d), int'(ddv));
    end
    e++;
  endtask

  task automatic cycle(input logic r, input logic [2:0] d, input logic ddv);
    @(negedge clk);
    step(r, d, ddv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0);
  endtask

  // Assert reset mid-cycle, check that outputs clear at once, then release at a
  // negedge with req held at hold_req (a held-high req counts as a rise).
  task automatic do_reset(input logic hold_req, input logic [2:0] d, input logic ddv);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ack",      32'(ack),      32'd0);
    check_eq("rst_done",     32'(done),     32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    req = hold_req;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(hold_req, d, ddv);
  endtask

  int r0;
  logic rr;

  initial begin
    rst = 1'b1; req = 1'b0; cfg_ack_dly = 3'd0; cfg_done_dly = 1'b0;
    clear_obs();
    last_ack_e = -1; last_done_e = -1;
    repeat (3) @(negedge clk);
    check_eq("init_ack",      32'(ack),      32'd0);
    check_eq("init_done",     32'(done),     32'd0);
    check_eq("init_busy",     32'(busy),     32'd0);
    check_eq("init_pend_cnt", 32'(pend_cnt), 32'd0);
    check_eq("init_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    model_reset();
    step(1'b0, 3'd0, 1'b0);
    idle(8);

    // Single request, D=0, done 1 cycle after ack.
    r0 = e;
    cycle(1'b1, 3'd0, 1'b0);
    cycle(1'b1, 3'd0, 1'b0);
    idle(8);
    check_eq("d0_ack_lat",  32'(last_ack_e - r0),  32'd2);
    check_eq("d0_done_lat", 32'(last_done_e - r0), 32'd3);

    // Single request, D=5, done 2 cycles after ack.
    clear_obs();
    r0 = e;
    cycle(1'b1, 3'd5, 1'b1);
    idle(14);
    check_eq("d5_ack_lat",  32'(last_ack_e - r0),  32'd7);
    check_eq("d5_done_lat", 32'(last_done_e - r0), 32'd9);
    check_eq("d5_pairs",    32'(obs_ack + obs_done), 32'd2);

    // Five request edges 2 cycles apart, D=7: three queue up, the fifth is dropped.
    clear_obs();
    for (int i = 0; i < 10; i++) cycle((i % 2) == 0, 3'd7, 1'b0);
    idle(50);
    check_eq("q_acks",    32'(obs_ack),     32'd4);
    check_eq("q_dones",   32'(obs_done),    32'd4);
    check_eq("q_ovf",     32'(obs_ovf),     32'd1);
    check_eq("q_maxpend", 32'(obs_maxpend), 32'd3);

    // A rise in the DONE cycle with nothing queued starts the next transaction at once.
    clear_obs();
    r0 = e;
    cycle(1'b1, 3'd2, 1'b0);            // ack r0+4, done r0+5
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd2, 1'b0);
    cycle(1'b1, 3'd2, 1'b0);            // rise exactly at the done edge
    idle(12);
    check_eq("dn_second_ack", 32'(last_ack_e - r0), 32'd9);
    check_eq("dn_maxpend",    32'(obs_maxpend),     32'd0);
    check_eq("dn_pairs",      32'(obs_done),        32'd2);

    // Config change one cycle after the rise must not affect that transaction.
    r0 = e;
    cycle(1'b1, 3'd4, 1'b0);
    cycle(1'b1, 3'd0, 1'b1);
    idle(12);
    check_eq("cfg_ack_lat", 32'(last_ack_e - r0), 32'd6);

    // Reset in the middle of DLY with two requests queued.
    cycle(1'b1, 3'd7, 1'b0);
    cycle(1'b0, 3'd7, 1'b0);
    cycle(1'b1, 3'd7, 1'b0);
    cycle(1'b0, 3'd7, 1'b0);
    cycle(1'b1, 3'd7, 1'b0);
    cycle(1'b1, 3'd7, 1'b0);
    check_eq("pre_rst_pend", 32'(pend_cnt), 32'd2);
    clear_obs();
    do_reset(1'b0, 3'd0, 1'b0);
    idle(30);
    check_eq("post_rst_acks",  32'(obs_ack),  32'd0);
    check_eq("post_rst_dones", 32'(obs_done), 32'd0);

    // A req already high when reset releases counts as a rise.
    clear_obs();
    do_reset(1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'd1, 1'b0);
    idle(5);
    check_eq("hi_at_release_acks", 32'(obs_ack), 32'd1);

    // Random traffic with the config changing every cycle.
    rr = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        do_reset(rr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 2) == 0) rr = ~rr;
        cycle(rr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Request/acknowledge/done responder that sits directly upstream of the req/ack/done protocol checker. It produces the `ack` and `done` handshakes that the checker's properties test. Each rising edge of `req` gets exactly one single-cycle `ack` after a programmable delay, then one single-cycle `done` 1 or 2 cycles after that `ack`. Rising edges that arrive while a transaction is in flight are counted and served in order, up to a bounded depth.

## Interface
- `DLY_W`, default 3: width of the ack-delay configuration; delay range is 0..2^DLY_W-1.
- `MAX_PEND`, default 3: maximum number of queued request edges; `PEND_W = $clog2(MAX_PEND+1)`.
- `clk` in 1: single clock; all logic is on the posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request level; only rising edges are significant.
- `cfg_ack_dly` in DLY_W: ack delay D, in cycles.
- `cfg_done_dly` in 1: 0 means done 1 cycle after ack; 1 means done 2 cycles after ack.
- `ack` out 1: single-cycle acknowledge pulse, registered.
- `done` out 1: single-cycle completion pulse, registered.
- `busy` out 1: high while state is not IDLE.
- `pend_cnt` out PEND_W: number of queued, not-yet-started requests.
- `overflow` out 1: single-cycle pulse when a request edge is dropped.

## Operation
- Edge detect: `req_q` registers `req` and resets to 0. `rose = req & ~req_q`.
- A request already high when `rst` releases counts as a rise.
- FSM states: IDLE, DLY, ACK, GAP, DONE. Reset state is IDLE.
- Start action: load `cnt` with `cfg_ack_dly` and latch `cfg_done_dly` into `dd`. Config changes mid-transaction have no effect on that transaction.
- IDLE: on `rose`, perform the start action and go to DLY.
- DLY: if `cnt == 0`, go to ACK; otherwise decrement `cnt`.
- ACK: go to GAP if `dd == 1`, else go to DONE.
- GAP: go to DONE.
- DONE: start the next transaction and go to DLY if `rose` or `pend_cnt > 0`; otherwise go to IDLE.
- In DONE, the queue is used before a simultaneous `rose`:
  - If `pend_cnt > 0`, it decrements, and a simultaneous `rose` increments it (net unchanged).
  - If `pend_cnt == 0` and `rose` is high, the new edge starts directly and `pend_cnt` stays 0.
- Outputs: `ack = (state == ACK)` and `done = (state == DONE)`, both registered from state. `ack` and `done` are never high in the same cycle.
- Queueing: a `rose` seen in DLY, ACK or GAP increments `pend_cnt`.
- `pend_cnt` saturates at MAX_PEND. A `rose` at saturation is dropped and `overflow` pulses for 1 cycle.
- Every accepted `rose` yields exactly one `ack` followed by exactly one `done`. There is never an `ack` without a `done`, and no `done` without a preceding `ack`.
- Reset values: `ack = 0`, `done = 0`, `busy = 0`, `pend_cnt = 0`, `overflow = 0`, `cnt = 0`, `dd = 0`, `req_q = 0`.
- Reset asserted mid-transaction clears everything immediately (asynchronous). No `ack` or `done` is emitted for the aborted or queued requests.

## Timing
- All edges below are edges at which signals are sampled.
- Let `rose` be sampled at edge N in IDLE with `cfg_ack_dly = D`:
  - `busy` is sampled 1 at N+1.
  - `ack` is sampled 1 at exactly N+2+D, for one edge only.
  - `done` is sampled 1 at exactly N+3+D+`cfg_done_dly`, for one edge only.
- `ack` to `done` is always 1 or 2 cycles. This satisfies the checker's `s_eventually ack` and `##[1:2] done`.
- Back-to-back: when the next transaction starts from DONE at edge M, its `ack` is at M+2+D'. The gap between `done` and the next `ack` is at least 2 cycles.
- A `rose` at N with `cfg_ack_dly = 0` gives `ack` at N+2, the minimum latency.
- `overflow` is sampled 1 at the edge after the dropped `rose`.
- `pend_cnt` updates 1 edge after the `rose` that changes it.

## Test plan
- Single request, D=0, cfg_done_dly=0: `req` rises at edge 10. Required: `ack` at 12, `done` at 13, `busy` 0 at 14.
- Single request, D=5, cfg_done_dly=1: `req` rises at edge 10. Required: `ack` at 17, `done` at 19. No other pulses.
- Queueing and overflow, MAX_PEND=3, D=7: five `req` pulses 2 cycles apart during a transaction.
  - Required: `pend_cnt` reaches 3, and `overflow` pulses once for the 5th edge.
  - Required: exactly 4 ack/done pairs in total, each `done` 1–2 cycles after its `ack`.
- Rise coincident with DONE, `pend_cnt = 0`: the next transaction starts immediately.
  - Required: `pend_cnt` stays 0; second `ack` at (done edge)+2+D.
- Config change mid-transaction: D=4, then `cfg_ack_dly` is set to 0 one cycle after the rise. Required: `ack` still at N+6.
- Reset mid-DLY with `pend_cnt = 2`. Required: all outputs are 0 immediately; no `ack` or `done` until a new rise after reset release.
